count_alarm: RTL and testbench
==============================

Name: count_alarm

Overview:
Consumes the free-running 32-bit count produced by the team's simple incrementing counter and raises programmable alarms when that count reaches a target.
- Supports one-shot and periodic modes.
- Comparison is wrap-around-safe.
- Provides a latched interrupt with acknowledge and a sticky missed-event flag.
- Sits directly downstream of the counter; feeds the interrupt/event logic.

Parameters:
WIDTH, 32, width of count_value, cfg_period and the internal target.
FIRE_CNT_W, 16, width of fire_count (saturating).

Ports:
clk  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-low reset.
count_value  input  WIDTH  current count from the upstream counter.
cfg_valid  input  1  config request.
cfg_ready  output  1  block can accept config this cycle.
cfg_period  input  WIDTH  ticks until first/next fire.
cfg_oneshot  input  1  1 = fire once then go IDLE; 0 = periodic.
cfg_err  output  1  1-cycle pulse: request rejected (period MSB set).
disarm  input  1  abort the armed alarm.
irq_ack  input  1  clears irq.
armed  output  1  state is ARMED.
alarm  output  1  1-cycle pulse per fire.
irq  output  1  level, set on fire, cleared by irq_ack.
missed  output  1  sticky: fire lost or periodic target overrun.
fire_count  output  FIRE_CNT_W  fires since last accepted config, saturating.

Behaviour:
- Reset (reset=0, asynchronous): all outputs to 0, including cfg_ready. State goes to IDLE and target goes to 0. cfg_ready goes to 1 on the first clock edge after reset is released.
- States:
  - IDLE: cfg_ready=1.
  - ARMED: cfg_ready=1; a new config re-arms.
  - There is no other state. irq is separate from the state.
- Handshake:
  - Accept occurs when cfg_valid && cfg_ready && !disarm.
  - disarm beats cfg_valid in the same cycle. In that case cfg_ready=0 and the request is not taken.
- Accept with cfg_period[WIDTH-1]=1:
  - cfg_err pulses the next cycle.
  - State and all other outputs are unchanged.
- Accept with a valid period:
  - period_eff = max(cfg_period,1).
  - target = count_value + period_eff, mod 2^WIDTH.
  - Latch oneshot. Clear missed and fire_count. Enter ARMED the next cycle.
- Compare (ARMED only):
  - hit = MSB of (count_value - target) mod 2^WIDTH equals 0, i.e. a signed difference >= 0.
  - Correct across the 0xFFFFFFFF->0 wrap when period < 2^(WIDTH-1).
- On hit, registered, latency 1:
  - alarm=1 for exactly 1 cycle. irq set. fire_count increments, saturating at all-ones.
  - If irq was already 1 and not being acked in that cycle, missed is set.
  - One-shot: go to IDLE.
  - Periodic: target = target + period_eff, which gives no drift.
  - If the new target still satisfies hit against the current count_value (upstream stalled, jumped, or period too small), set missed and use target = count_value + period_eff instead.
- irq_ack and fire in the same cycle: set wins, so irq stays 1 and missed is unchanged.
- disarm in ARMED: go to IDLE next cycle.
  - A hit in the same cycle is suppressed: no alarm.
  - irq and missed are unaffected.
- Upstream counter reset: count drops to 0, the difference goes negative, and no false fire occurs. The alarm fires when the count re-reaches target.
- Reset mid-operation: immediate return to reset values. A pending irq is lost.
- Arithmetic: all sums and differences use WIDTH bits with natural wrap. There are no carries out.

Decomposition:
- Package count_pkg holds:
  - COUNT_W = 32 and FIRE_CNT_W = 16 default constants.
  - State encoding: IDLE=1'b0, ARMED=1'b1.
  - Helper constant PERIOD_MAX = 2^(WIDTH-1)-1.
- One sub-module, wrap_ge: combinational wrap-safe comparator (a, b) -> ge = ~(a-b)[WIDTH-1].
  - Instantiated twice: once for the hit test, once for the periodic overrun test.

Test Plan:
- Counter increments each clk from 0; cfg accepted at count=10 with period=5, oneshot=1 -> alarm pulses once on the cycle after count=15; irq=1; armed=0; fire_count=1.
- Periodic, period=4, accepted at count=0, irq_ack each fire -> alarms after counts 4, 8, 12, 16; missed=0; fire_count=4.
- Accept at count=0xFFFFFFFD with period=6 -> no fire before the wrap; alarm after count=3.
- Periodic period=3 with no irq_ack -> the first fire sets irq; the second fire sets missed=1. A new cfg accept clears missed and fire_count.
- Same-cycle cases:
  - disarm with cfg_valid -> cfg_ready=0, config not taken.
  - disarm on the hit cycle -> no alarm.
  - irq_ack on a fire cycle -> irq remains 1.
- cfg_period=0x80000000 -> cfg_err pulse, state unchanged. Reset asserted while ARMED with irq=1 -> all outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/count_alarm_pkg.sv
// count_alarm shared constants and state encoding.
// Revision: 1.0
`default_nettype none
package count_pkg;
  localparam int COUNT_W    = 32;
  localparam int FIRE_CNT_W = 16;
  localparam logic [COUNT_W-1:0] PERIOD_MAX = {1'b0, {(COUNT_W-1){1'b1}}};

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;
endpackage
`default_nettype wire

// File: rtl/count_alarm_if.sv
// Configuration / control handshake between the alarm block and its host.
// Revision: 1.0
`default_nettype none
interface count_alarm_if import count_pkg::*; #(
  parameter int WIDTH = COUNT_W
) ();
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_period;
  logic             cfg_oneshot;
  logic             cfg_err;
  logic             disarm;

  modport master (
    output cfg_valid, cfg_period, cfg_oneshot, disarm,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_period, cfg_oneshot, disarm,
    output cfg_ready, cfg_err
  );
endinterface
`default_nettype wire

// File: rtl/count_alarm_wrap_ge.sv
// Wrap-around-safe a >= b: true when the modular difference is non-negative.
// Revision: 1.0
`default_nettype none
module wrap_ge import count_pkg::*; #(
  parameter int WIDTH = COUNT_W
) (
  input  wire logic [WIDTH-1:0] i_a,
  input  wire logic [WIDTH-1:0] i_b,
  output logic                  o_ge
);
  logic [WIDTH-1:0] w_diff;

  assign w_diff = i_a - i_b;
  assign o_ge   = ~w_diff[WIDTH-1];
endmodule
`default_nettype wire

// File: rtl/count_alarm.sv
// Programmable one-shot / periodic alarm on a free-running count, with latched irq.
// Revision: 1.0
`default_nettype none
module count_alarm import count_pkg::*; #(
  parameter int WIDTH      = COUNT_W,
  parameter int FIRE_CNT_W = count_pkg::FIRE_CNT_W
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic [WIDTH-1:0]      i_count_value,
  count_alarm_if.slave               cfg,
  input  wire logic                  i_irq_ack,
  output logic                       o_armed,
  output logic                       o_alarm,
  output logic                       o_irq,
  output logic                       o_missed,
  output logic [FIRE_CNT_W-1:0]      o_fire_count
);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t                r_state, w_state_nxt;
  logic [WIDTH-1:0]      r_target, w_target_nxt;
  logic [WIDTH-1:0]      r_period, w_period_nxt;
  logic                  r_oneshot, w_oneshot_nxt;
  logic                  r_alarm, w_alarm_nxt;
  logic                  r_irq, w_irq_nxt;
  logic                  r_missed, w_missed_nxt;
  logic                  r_err, w_err_nxt;
  logic [FIRE_CNT_W-1:0] r_fire_cnt, w_fire_cnt_nxt;
  logic                  r_ready;

  logic             w_accept, w_bad, w_arm, w_hit, w_fire;
  logic             w_ge_hit, w_ge_overrun;
  logic [WIDTH-1:0] w_period_eff, w_target_step, w_target_resync;

  // disarm takes priority over a simultaneous config request
  assign w_accept        = cfg.cfg_valid & r_ready & ~cfg.disarm;
  assign w_bad           = cfg.cfg_period[WIDTH-1];
  assign w_arm           = w_accept & ~w_bad;
  assign w_period_eff    = (cfg.cfg_period == '0) ? ONE : cfg.cfg_period;
  assign w_target_step   = r_target + r_period;
  assign w_target_resync = i_count_value + r_period;

  wrap_ge #(.WIDTH(WIDTH)) u_hit_cmp (
    .i_a  (i_count_value),
    .i_b  (r_target),
    .o_ge (w_ge_hit)
  );

  wrap_ge #(.WIDTH(WIDTH)) u_overrun_cmp (
    .i_a  (i_count_value),
    .i_b  (w_target_step),
    .o_ge (w_ge_overrun)
  );

  assign w_hit  = (r_state == ARMED) & w_ge_hit;
  assign w_fire = w_hit & ~cfg.disarm & ~w_arm;

  always_comb begin
    w_state_nxt    = r_state;
    w_target_nxt   = r_target;
    w_period_nxt   = r_period;
    w_oneshot_nxt  = r_oneshot;
    w_alarm_nxt    = 1'b0;
    w_missed_nxt   = r_missed;
    w_fire_cnt_nxt = r_fire_cnt;
    w_err_nxt      = w_accept & w_bad;
    w_irq_nxt      = r_irq;

    if (w_arm) begin
      w_state_nxt    = ARMED;
      w_target_nxt   = i_count_value + w_period_eff;
      w_period_nxt   = w_period_eff;
      w_oneshot_nxt  = cfg.cfg_oneshot;
      w_missed_nxt   = 1'b0;
      w_fire_cnt_nxt = '0;
    end else if ((r_state == ARMED) && cfg.disarm) begin
      w_state_nxt = IDLE;
    end else if (w_fire) begin
      w_alarm_nxt = 1'b1;
      if (r_fire_cnt != '1) begin
        w_fire_cnt_nxt = r_fire_cnt + FIRE_CNT_W'(1);
      end
      if (r_irq && !i_irq_ack) begin
        w_missed_nxt = 1'b1;
      end
      if (r_oneshot) begin
        w_state_nxt = IDLE;
      end else if (w_ge_overrun) begin
        // next slot already passed: resync to the live count instead of chasing it
        w_missed_nxt = 1'b1;
        w_target_nxt = w_target_resync;
      end else begin
        w_target_nxt = w_target_step;
      end
    end

    if (w_fire) begin
      w_irq_nxt = 1'b1;
    end else if (i_irq_ack) begin
      w_irq_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_target   <= '0;
      r_period   <= '0;
      r_oneshot  <= 1'b0;
      r_alarm    <= 1'b0;
      r_irq      <= 1'b0;
      r_missed   <= 1'b0;
      r_err      <= 1'b0;
      r_fire_cnt <= '0;
      r_ready    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_target   <= w_target_nxt;
      r_period   <= w_period_nxt;
      r_oneshot  <= w_oneshot_nxt;
      r_alarm    <= w_alarm_nxt;
      r_irq      <= w_irq_nxt;
      r_missed   <= w_missed_nxt;
      r_err      <= w_err_nxt;
      r_fire_cnt <= w_fire_cnt_nxt;
      r_ready    <= 1'b1;
    end
  end

  assign cfg.cfg_ready = r_ready & ~cfg.disarm;
  assign cfg.cfg_err   = r_err;
  assign o_armed       = (r_state == ARMED);
  assign o_alarm       = r_alarm;
  assign o_irq         = r_irq;
  assign o_missed      = r_missed;
  assign o_fire_count  = r_fire_cnt;
endmodule
`default_nettype wire

// File: tb/tb_count_alarm.sv
// Directed-vector bench for count_alarm.
// Revision: 1.0
`default_nettype none
module tb_count_alarm;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] count_value = '0;
  logic        irq_ack = 1'b0;
  logic        armed, alarm, irq, missed;
  logic [15:0] fire_count;
  int          n_cmp = 0;
  int          n_bad = 0;

  count_alarm_if cfg_if ();

  count_alarm u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_count_value(count_value),
    .cfg          (cfg_if.slave),
    .i_irq_ack    (irq_ack),
    .o_armed      (armed),
    .o_alarm      (alarm),
    .o_irq        (irq),
    .o_missed     (missed),
    .o_fire_count (fire_count)
  );

  always #5 clk = ~clk;

  // flags = {armed, alarm, irq, missed, cfg_err, cfg_ready}
  typedef struct packed {
    logic [31:0] c;
    logic        v;
    logic [31:0] p;
    logic        os;
    logic        d;
    logic        a;
    logic [5:0]  e_flags;
    logic [15:0] e_fc;
  } vec_t;

  vec_t vecs [0:37];

  function automatic vec_t mk(input logic [31:0] c, input logic v, input logic [31:0] p,
                              input logic os, input logic d, input logic a,
                              input logic [5:0] ef, input logic [15:0] efc);
    vec_t r;
    r.c = c; r.v = v; r.p = p; r.os = os; r.d = d; r.a = a;
    r.e_flags = ef; r.e_fc = efc;
    return r;
  endfunction

  task automatic drive(input logic [31:0] c, input logic v, input logic [31:0] p,
                       input logic os, input logic d, input logic a);
    count_value        = c;
    cfg_if.cfg_valid   = v;
    cfg_if.cfg_period  = p;
    cfg_if.cfg_oneshot = os;
    cfg_if.disarm      = d;
    irq_ack            = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [5:0] ef, input logic [15:0] efc);
    logic [5:0] af;
    af = {armed, alarm, irq, missed, cfg_if.cfg_err, cfg_if.cfg_ready};
    n_cmp++;
    if (af !== ef || fire_count !== efc) begin
      n_bad++;
      $display("FAIL %s: got flags=%b fire_count=%0d, expected flags=%b fire_count=%0d",
               name, af, fire_count, ef, efc);
    end
  endtask

  initial begin
    logic exp_al;
    logic prev_fire;
    drive(32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

    vecs[0]  = mk(32'd0,          0, 32'd0,          0, 0, 0, 6'b000001, 16'd0);
    vecs[1]  = mk(32'd10,         1, 32'd5,          1, 0, 0, 6'b100001, 16'd0);
    vecs[2]  = mk(32'd11,         0, 32'd0,          0, 0, 0, 6'b100001, 16'd0);
    vecs[3]  = mk(32'd14,         0, 32'd0,          0, 0, 0, 6'b100001, 16'd0);
    vecs[4]  = mk(32'd15,         0, 32'd0,          0, 0, 0, 6'b011001, 16'd1);
    vecs[5]  = mk(32'd16,         0, 32'd0,          0, 0, 0, 6'b001001, 16'd1);
    vecs[6]  = mk(32'd17,         0, 32'd0,          0, 0, 1, 6'b000001, 16'd1);
    vecs[7]  = mk(32'd18,         1, 32'h8000_0000,  0, 0, 0, 6'b000011, 16'd1);
    vecs[8]  = mk(32'd19,         0, 32'd0,          0, 0, 0, 6'b000001, 16'd1);
    vecs[9]  = mk(32'd20,         1, 32'd5,          0, 1, 0, 6'b000000, 16'd1);
    vecs[10] = mk(32'd30,         0, 32'd0,          0, 0, 0, 6'b000001, 16'd1);
    vecs[11] = mk(32'd100,        1, 32'd3,          0, 0, 0, 6'b100001, 16'd0);
    vecs[12] = mk(32'd103,        0, 32'd0,          0, 0, 0, 6'b111001, 16'd1);
    vecs[13] = mk(32'd104,        0, 32'd0,          0, 0, 0, 6'b101001, 16'd1);
    vecs[14] = mk(32'd106,        0, 32'd0,          0, 0, 0, 6'b111101, 16'd2);
    vecs[15] = mk(32'd107,        0, 32'd0,          0, 0, 1, 6'b100101, 16'd2);
    vecs[16] = mk(32'd200,        1, 32'd3,          0, 0, 0, 6'b100001, 16'd0);
    vecs[17] = mk(32'd203,        0, 32'd0,          0, 0, 0, 6'b111001, 16'd1);
    vecs[18] = mk(32'd206,        0, 32'd0,          0, 0, 1, 6'b111001, 16'd2);
    vecs[19] = mk(32'd209,        0, 32'd0,          0, 1, 0, 6'b001000, 16'd2);
    vecs[20] = mk(32'd210,        0, 32'd0,          0, 0, 0, 6'b001001, 16'd2);
    vecs[21] = mk(32'd300,        1, 32'd2,          0, 0, 1, 6'b100001, 16'd0);
    vecs[22] = mk(32'd310,        0, 32'd0,          0, 0, 0, 6'b111101, 16'd1);
    vecs[23] = mk(32'd311,        0, 32'd0,          0, 0, 0, 6'b101101, 16'd1);
    vecs[24] = mk(32'd312,        0, 32'd0,          0, 0, 1, 6'b111101, 16'd2);
    vecs[25] = mk(32'd400,        1, 32'd0,          1, 0, 1, 6'b100001, 16'd0);
    vecs[26] = mk(32'd400,        0, 32'd0,          0, 0, 0, 6'b100001, 16'd0);
    vecs[27] = mk(32'd401,        0, 32'd0,          0, 0, 0, 6'b011001, 16'd1);
    vecs[28] = mk(32'd1000,       1, 32'd10,         1, 0, 1, 6'b100001, 16'd0);
    vecs[29] = mk(32'd0,          0, 32'd0,          0, 0, 0, 6'b100001, 16'd0);
    vecs[30] = mk(32'd5,          0, 32'd0,          0, 0, 0, 6'b100001, 16'd0);
    vecs[31] = mk(32'd1010,       0, 32'd0,          0, 0, 0, 6'b011001, 16'd1);
    vecs[32] = mk(32'hFFFF_FFFD,  1, 32'd6,          1, 0, 1, 6'b100001, 16'd0);
    vecs[33] = mk(32'hFFFF_FFFE,  0, 32'd0,          0, 0, 0, 6'b100001, 16'd0);
    vecs[34] = mk(32'hFFFF_FFFF,  0, 32'd0,          0, 0, 0, 6'b100001, 16'd0);
    vecs[35] = mk(32'd0,          0, 32'd0,          0, 0, 0, 6'b100001, 16'd0);
    vecs[36] = mk(32'd2,          0, 32'd0,          0, 0, 0, 6'b100001, 16'd0);
    vecs[37] = mk(32'd3,          0, 32'd0,          0, 0, 0, 6'b011001, 16'd1);

    #12;
    check("in_reset", 6'b000000, 16'd0);
    #1 rst_n = 1'b1;
    #1;
    check("post_release_no_edge", 6'b000000, 16'd0);

    for (int i = 0; i < 38; i++) begin
      drive(vecs[i].c, vecs[i].v, vecs[i].p, vecs[i].os, vecs[i].d, vecs[i].a);
      tick();
      check($sformatf("vec%0d", i), vecs[i].e_flags, vecs[i].e_fc);
    end

    // periodic period=4 on an incrementing count, acking every fire
    drive(32'd0, 1'b1, 32'd4, 1'b0, 1'b0, 1'b1);
    tick();
    check("per4_accept", 6'b100001, 16'd0);
    prev_fire = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      drive(32'(k), 1'b0, 32'd0, 1'b0, 1'b0, prev_fire);
      tick();
      exp_al = (k % 4 == 0) && (k <= 16);
      n_cmp++;
      if (alarm !== exp_al) begin
        n_bad++;
        $display("FAIL per4_alarm_k%0d: got %b, expected %b", k, alarm, exp_al);
      end
      prev_fire = exp_al;
    end
    check("per4_final", 6'b100001, 16'd4);

    // build ARMED with irq pending, then assert reset between edges
    drive(32'd50, 1'b1, 32'd1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'd51, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("pre_rst_fire", 6'b011001, 16'd1);
    drive(32'd52, 1'b1, 32'd100, 1'b1, 1'b0, 1'b0);
    tick();
    check("pre_rst_armed_irq", 6'b101001, 16'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", 6'b000000, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
